// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI-Lite command master.
// Holds the FSM encoding, response codes and strobe width helper.
package axil_cmd_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

   localparam int RESP_OKAY   = 0;
   localparam int RESP_SLVERR = 2;

   function automatic int strb_width(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding command/response to AXI4-Lite master.
// One write or read is in flight at a time; all bus outputs are registered.
module axil_cmd_master
   import axil_cmd_master_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                m3_axi_aclk,
   input  logic                                m3_axi_aresetn,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic                                cmd_write,
   input  logic [ADDR_WIDTH-1:0]               cmd_addr,
   input  logic [DATA_WIDTH-1:0]               cmd_wdata,
   input  logic [strb_width(DATA_WIDTH)-1:0]   cmd_wstrb,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic                                rsp_write,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic [RESP_WIDTH-1:0]               rsp_resp,
   output logic [ADDR_WIDTH-1:0]               m3_axi_awaddr,
   output logic                                m3_axi_awvalid,
   input  logic                                m3_axi_awready,
   output logic [DATA_WIDTH-1:0]               m3_axi_wdata,
   output logic [strb_width(DATA_WIDTH)-1:0]   m3_axi_wstrb,
   output logic                                m3_axi_wvalid,
   input  logic                                m3_axi_wready,
   input  logic [RESP_WIDTH-1:0]               m3_axi_bresp,
   input  logic                                m3_axi_bvalid,
   output logic                                m3_axi_bready,
   output logic [ADDR_WIDTH-1:0]               m3_axi_araddr,
   output logic                                m3_axi_arvalid,
   input  logic                                m3_axi_arready,
   input  logic [DATA_WIDTH-1:0]               m3_axi_rdata,
   input  logic [RESP_WIDTH-1:0]               m3_axi_rresp,
   input  logic                                m3_axi_rvalid,
   output logic                                m3_axi_rready,
   output logic [CNT_WIDTH-1:0]                wr_count,
   output logic [CNT_WIDTH-1:0]                rd_count,
   output logic [CNT_WIDTH-1:0]                err_count
);

   localparam logic [RESP_WIDTH-1:0] OKAY = RESP_WIDTH'(RESP_OKAY);

   state_t state_q, state_d;
   logic   aw_done, w_done;
   logic   cmd_fire, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic   aw_ok, w_ok;

   // Gated by reset so nothing is offered while the block is held in reset.
   assign cmd_ready = m3_axi_aresetn & (state_q == ST_IDLE);
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign aw_hs     = m3_axi_awvalid & m3_axi_awready;
   assign w_hs      = m3_axi_wvalid & m3_axi_wready;
   assign b_hs      = m3_axi_bvalid & m3_axi_bready;
   assign ar_hs     = m3_axi_arvalid & m3_axi_arready;
   assign r_hs      = m3_axi_rvalid & m3_axi_rready;
   assign aw_ok     = aw_done | aw_hs;
   assign w_ok      = w_done | w_hs;

   always_ff @(posedge m3_axi_aclk or negedge m3_axi_aresetn) begin
      if (!m3_axi_aresetn) state_q <= ST_IDLE;
      else                 state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (cmd_fire) state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
         ST_WR_REQ:
            if (aw_ok && w_ok) state_d = ST_WR_RESP;
         ST_WR_RESP:
            if (b_hs) state_d = ST_RSP;
         ST_RD_REQ:
            if (ar_hs) state_d = ST_RD_RESP;
         ST_RD_RESP:
            if (r_hs) state_d = ST_RSP;
         ST_RSP:
            if (rsp_ready) state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge m3_axi_aclk or negedge m3_axi_aresetn) begin
      if (!m3_axi_aresetn) begin
         m3_axi_awaddr  <= '0;
         m3_axi_awvalid <= 1'b0;
         m3_axi_wdata   <= '0;
         m3_axi_wstrb   <= '0;
         m3_axi_wvalid  <= 1'b0;
         m3_axi_bready  <= 1'b0;
         m3_axi_araddr  <= '0;
         m3_axi_arvalid <= 1'b0;
         m3_axi_rready  <= 1'b0;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_write      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_resp       <= '0;
         wr_count       <= '0;
         rd_count       <= '0;
         err_count      <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_fire && cmd_write) begin
                  m3_axi_awaddr  <= cmd_addr;
                  m3_axi_wdata   <= cmd_wdata;
                  m3_axi_wstrb   <= cmd_wstrb;
                  m3_axi_awvalid <= 1'b1;
                  m3_axi_wvalid  <= 1'b1;
                  aw_done        <= 1'b0;
                  w_done         <= 1'b0;
               end else if (cmd_fire) begin
                  m3_axi_araddr  <= cmd_addr;
                  m3_axi_arvalid <= 1'b1;
               end
            end
            ST_WR_REQ: begin
               if (aw_hs) begin
                  m3_axi_awvalid <= 1'b0;
                  aw_done        <= 1'b1;
               end
               if (w_hs) begin
                  m3_axi_wvalid <= 1'b0;
                  w_done        <= 1'b1;
               end
               if (aw_ok && w_ok) m3_axi_bready <= 1'b1;
            end
            ST_WR_RESP: begin
               if (b_hs) begin
                  m3_axi_bready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_write     <= 1'b1;
                  rsp_rdata     <= '0;
                  rsp_resp      <= m3_axi_bresp;
                  wr_count      <= wr_count + 1'b1;
                  if (m3_axi_bresp != OKAY) err_count <= err_count + 1'b1;
               end
            end
            ST_RD_REQ: begin
               if (ar_hs) begin
                  m3_axi_arvalid <= 1'b0;
                  m3_axi_rready  <= 1'b1;
               end
            end
            ST_RD_RESP: begin
               if (r_hs) begin
                  m3_axi_rready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_write     <= 1'b0;
                  rsp_rdata     <= m3_axi_rdata;
                  rsp_resp      <= m3_axi_rresp;
                  rd_count      <= rd_count + 1'b1;
                  if (m3_axi_rresp != OKAY) err_count <= err_count + 1'b1;
               end
            end
            ST_RSP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Randomized bench for axil_cmd_master with an in-bench AXI-Lite slave
// and a word-memory reference model of expected responses and counters.
module tb_axil_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
   logic [31:0] rsp_rdata;
   logic [2:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic        awvalid, awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready = 1'b0;
   logic [2:0]  bresp = '0;
   logic        bvalid = 1'b0, bready;
   logic        arvalid, arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [2:0]  rresp = '0;
   logic        rvalid = 1'b0, rready;
   logic [15:0] wr_count, rd_count, err_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [15:0] exp_wr = '0, exp_rd = '0, exp_err = '0;
   logic [31:0] ref_mem [64];
   logic [31:0] smem [64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axil_cmd_master dut (
      .m3_axi_aclk(clk), .m3_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m3_axi_awaddr(awaddr), .m3_axi_awvalid(awvalid), .m3_axi_awready(awready),
      .m3_axi_wdata(wdata), .m3_axi_wstrb(wstrb), .m3_axi_wvalid(wvalid),
      .m3_axi_wready(wready), .m3_axi_bresp(bresp), .m3_axi_bvalid(bvalid),
      .m3_axi_bready(bready), .m3_axi_araddr(araddr), .m3_axi_arvalid(arvalid),
      .m3_axi_arready(arready), .m3_axi_rdata(rdata), .m3_axi_rresp(rresp),
      .m3_axi_rvalid(rvalid), .m3_axi_rready(rready),
      .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
   );

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic slave_aw(input logic [7:0] a, input int d);
      for (int i = 0; i < d; i++) begin
         checks++;
         if (awvalid !== 1'b1 || awaddr !== a || bready !== 1'b0) begin
            failures++;
            $display("FAIL aw_hold awvalid=%b awaddr=%h bready=%b want 1 %h 0",
                     awvalid, awaddr, bready, a);
         end
         @(posedge clk); #1;
      end
      awready = 1'b1;
      checks++;
      if (awvalid !== 1'b1 || awaddr !== a || bready !== 1'b0) begin
         failures++;
         $display("FAIL aw_hs awvalid=%b awaddr=%h bready=%b want 1 %h 0",
                  awvalid, awaddr, bready, a);
      end
      @(posedge clk); #1;
      awready = 1'b0;
      checks++;
      if (awvalid !== 1'b0) begin
         failures++;
         $display("FAIL aw_drop awvalid=%b want 0", awvalid);
      end
   endtask

   task automatic slave_w(input logic [31:0] dv, input logic [3:0] sv, input int d);
      for (int i = 0; i < d; i++) begin
         checks++;
         if (wvalid !== 1'b1 || wdata !== dv || wstrb !== sv || bready !== 1'b0) begin
            failures++;
            $display("FAIL w_hold wvalid=%b wdata=%h wstrb=%h bready=%b want 1 %h %h 0",
                     wvalid, wdata, wstrb, bready, dv, sv);
         end
         @(posedge clk); #1;
      end
      wready = 1'b1;
      checks++;
      if (wvalid !== 1'b1 || wdata !== dv || wstrb !== sv || bready !== 1'b0) begin
         failures++;
         $display("FAIL w_hs wvalid=%b wdata=%h wstrb=%h bready=%b want 1 %h %h 0",
                  wvalid, wdata, wstrb, bready, dv, sv);
      end
      smem[awaddr[7:2]] = merge(smem[awaddr[7:2]], wdata, wstrb);
      @(posedge clk); #1;
      wready = 1'b0;
      checks++;
      if (wvalid !== 1'b0) begin
         failures++;
         $display("FAIL w_drop wvalid=%b want 0", wvalid);
      end
   endtask

   task automatic slave_ar(input logic [7:0] a, input int d);
      for (int i = 0; i <= d; i++) begin
         if (i == d) arready = 1'b1;
         checks++;
         if (arvalid !== 1'b1 || araddr !== a || rready !== 1'b0) begin
            failures++;
            $display("FAIL ar_hold arvalid=%b araddr=%h rready=%b want 1 %h 0",
                     arvalid, araddr, rready, a);
         end
         @(posedge clk); #1;
      end
      arready = 1'b0;
      checks++;
      if (arvalid !== 1'b0) begin
         failures++;
         $display("FAIL ar_drop arvalid=%b want 0", arvalid);
      end
   endtask

   task automatic run_txn(input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd,
                          input logic [2:0] resp, input int rspd,
                          input logic early);
      int acc;
      logic [31:0] exp_d;
      if (wr) begin
         ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], data, strb);
         exp_d = '0;
      end else begin
         exp_d = ref_mem[addr[7:2]];
      end
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      acc = cyc;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL cmd_ready_idle got=%b want 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_addr  = 8'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
      if (wr) begin
         if (early) begin
            bvalid = 1'b1;
            bresp  = resp;
         end
         fork
            slave_aw(addr, awd);
            slave_w(data, strb, wd);
         join
         if (!early) begin
            for (int i = 0; i < bd; i++) begin
               checks++;
               if (bready !== 1'b1 || rsp_valid !== 1'b0) begin
                  failures++;
                  $display("FAIL b_wait bready=%b rsp_valid=%b want 1 0", bready, rsp_valid);
               end
               @(posedge clk); #1;
            end
            bvalid = 1'b1;
            bresp  = resp;
         end
         checks++;
         if (bready !== 1'b1) begin
            failures++;
            $display("FAIL b_ready got=%b want 1", bready);
         end
         @(posedge clk); #1;
         bvalid = 1'b0;
         bresp  = 3'($urandom);
         checks++;
         if (bready !== 1'b0) begin
            failures++;
            $display("FAIL b_drop bready=%b want 0", bready);
         end
      end else begin
         slave_ar(addr, awd);
         for (int i = 0; i < bd; i++) begin
            checks++;
            if (rready !== 1'b1 || rsp_valid !== 1'b0) begin
               failures++;
               $display("FAIL r_wait rready=%b rsp_valid=%b want 1 0", rready, rsp_valid);
            end
            @(posedge clk); #1;
         end
         rvalid = 1'b1;
         rdata  = smem[addr[7:2]];
         rresp  = resp;
         checks++;
         if (rready !== 1'b1) begin
            failures++;
            $display("FAIL r_ready got=%b want 1", rready);
         end
         @(posedge clk); #1;
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 3'($urandom);
         checks++;
         if (rready !== 1'b0) begin
            failures++;
            $display("FAIL r_drop rready=%b want 0", rready);
         end
      end
      if (wr) exp_wr++;
      else    exp_rd++;
      if (resp != 3'd0) exp_err++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_write !== wr || rsp_rdata !== exp_d ||
          rsp_resp !== resp || cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL rsp v=%b w=%b d=%h r=%0d cr=%b want 1 %b %h %0d 0",
                  rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready,
                  wr, exp_d, resp);
      end
      if (awd == 0 && wd == 0 && bd == 0 && !early) begin
         checks++;
         if (cyc - acc != 3) begin
            failures++;
            $display("FAIL latency got=%0d want 3", cyc - acc);
         end
      end
      checks++;
      if (wr_count !== exp_wr || rd_count !== exp_rd || err_count !== exp_err) begin
         failures++;
         $display("FAIL counters got=%0d/%0d/%0d want %0d/%0d/%0d",
                  wr_count, rd_count, err_count, exp_wr, exp_rd, exp_err);
      end
      for (int i = 0; i < rspd; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_resp !== resp || rsp_rdata !== exp_d ||
             cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rsp_hold v=%b r=%0d d=%h cr=%b want 1 %0d %h 0",
                     rsp_valid, rsp_resp, rsp_rdata, cmd_ready, resp, exp_d);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rsp_done rsp_valid=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0 ||
          arvalid !== 1'b0 || bready !== 1'b0 || rready !== 1'b0 ||
          rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl cr=%b aw=%b w=%b ar=%b b=%b r=%b rv=%b want all 0",
                  cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid);
      end
      checks++;
      if (awaddr !== 8'd0 || araddr !== 8'd0 || wdata !== 32'd0 || wstrb !== 4'd0 ||
          rsp_rdata !== 32'd0 || rsp_resp !== 3'd0 || rsp_write !== 1'b0 ||
          wr_count !== 16'd0 || rd_count !== 16'd0 || err_count !== 16'd0) begin
         failures++;
         $display("FAIL reset_data awaddr=%h wdata=%h rdata=%h cnt=%0d/%0d/%0d want all 0",
                  awaddr, wdata, rsp_rdata, wr_count, rd_count, err_count);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release cmd_ready=%b want 1", cmd_ready);
      end
   endtask

   task automatic test_write_basic();
      run_txn(1'b1, 8'd0, 32'd25, 4'd15, 0, 0, 0, 3'd0, 0, 1'b0);
   endtask

   task automatic test_write_skew();
      run_txn(1'b1, 8'd4, 32'd34, 4'hF, 3, 0, 0, 3'd0, 0, 1'b0);
   endtask

   task automatic test_read();
      run_txn(1'b1, 8'd8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 3'd0, 0, 1'b0);
      run_txn(1'b0, 8'd8, 32'd0, 4'd0, 0, 0, 5, 3'd0, 0, 1'b0);
   endtask

   task automatic test_err_backpressure();
      run_txn(1'b0, 8'd12, 32'd0, 4'd0, 1, 0, 1, 3'd2, 4, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h20;
      cmd_wdata = 32'h1234_5678;
      cmd_wstrb = 4'hF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset awvalid=%b wvalid=%b want 1 1", awvalid, wvalid);
      end
      rst_n = 1'b0;
      #1;
      exp_wr = '0; exp_rd = '0; exp_err = '0;
      checks++;
      if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0 ||
          wr_count !== 16'd0 || rd_count !== 16'd0 || err_count !== 16'd0) begin
         failures++;
         $display("FAIL mid_reset aw=%b w=%b b=%b cr=%b rv=%b cnt=%0d/%0d/%0d want 0s",
                  awvalid, wvalid, bready, cmd_ready, rsp_valid,
                  wr_count, rd_count, err_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset cmd_ready=%b awvalid=%b want 1 0", cmd_ready, awvalid);
      end
      run_txn(1'b1, 8'h20, 32'hCAFE_F00D, 4'h5, 0, 0, 0, 3'd0, 0, 1'b0);
      run_txn(1'b0, 8'h20, 32'd0, 4'd0, 0, 0, 0, 3'd0, 0, 1'b0);
   endtask

   task automatic test_early_bvalid();
      run_txn(1'b1, 8'd16, 32'hA5A5_0F0F, 4'hF, 2, 3, 0, 3'd0, 0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wr_count !== exp_wr || err_count !== exp_err) begin
         failures++;
         $display("FAIL early_b_single wr=%0d err=%0d want %0d %0d",
                  wr_count, err_count, exp_wr, exp_err);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [2:0] r;
         r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         run_txn(1'($urandom), {6'($urandom), 2'b00}, $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 r, $urandom_range(0, 3), 1'($urandom_range(0, 4) == 0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = '0;
         smem[i] = '0;
      end
      test_reset();
      test_write_basic();
      test_write_skew();
      test_read();
      test_err_backpressure();
      test_reset_mid_write();
      test_early_bvalid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
AXI4-Lite master that converts a simple single-outstanding command/response interface into AXI-Lite write and read transactions. It sits directly upstream of the s3 AXI-Lite slave wrapper and drives its five channels. It replaces hand-driven bench stimulus and is also used by on-chip controllers that need register access. Exactly one transaction is in flight at any time.

Parameters:
DATA_WIDTH, 32, data bus width (multiple of 8)
ADDR_WIDTH, 8, byte address width
RESP_WIDTH, 3, width of bresp/rresp and of the returned response code
CNT_WIDTH, 16, width of the statistics counters

Ports:
m3_axi_aclk  in  1  clock
m3_axi_aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  echoes cmd_write
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  RESP_WIDTH  captured bresp or rresp
m3_axi_awaddr  out  ADDR_WIDTH  write address
m3_axi_awvalid  out  1
m3_axi_awready  in  1
m3_axi_wdata  out  DATA_WIDTH
m3_axi_wstrb  out  DATA_WIDTH/8
m3_axi_wvalid  out  1
m3_axi_wready  in  1
m3_axi_bresp  in  RESP_WIDTH
m3_axi_bvalid  in  1
m3_axi_bready  out  1
m3_axi_araddr  out  ADDR_WIDTH
m3_axi_arvalid  out  1
m3_axi_arready  in  1
m3_axi_rdata  in  DATA_WIDTH
m3_axi_rresp  in  RESP_WIDTH
m3_axi_rvalid  in  1
m3_axi_rready  out  1
wr_count  out  CNT_WIDTH  completed writes
rd_count  out  CNT_WIDTH  completed reads
err_count  out  CNT_WIDTH  completions with resp != 0

Behaviour:
- Reset (async assert, sync release): state IDLE. All valid/ready outputs and rsp_valid are 0. All address, data, strobe and rsp_* registers are 0. Counters are 0. cmd_ready is 0 during reset.
- All outputs are registered except cmd_ready, which is (state==IDLE).
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: on cmd_valid&cmd_ready, latch the command.
  - Write: awaddr/wdata/wstrb <= cmd fields; awvalid=wvalid=1; go to WR_REQ.
  - Read: araddr <= cmd_addr; arvalid=1; go to RD_REQ.
- WR_REQ: awvalid and wvalid are independent.
  - Each drops the cycle after its own handshake; tracked by aw_done/w_done flags.
  - A valid is never withdrawn before its handshake, and the payload stays stable.
  - When both are done (same or different cycles), go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, capture bresp, set rsp_rdata=0, drop bready, set rsp_valid=1, go to RSP.
  - A bvalid arriving before WR_RESP is ignored until bready rises.
- RD_REQ: hold arvalid until arready. Then drop arvalid, set rready=1, go to RD_RESP.
- RD_RESP: on rvalid&rready, capture rdata and rresp, drop rready, set rsp_valid=1, go to RSP.
- RSP: hold rsp_* stable until rsp_ready, then clear rsp_valid and return to IDLE.
  - A new command can be accepted on the following cycle (no back-to-back overlap).
- Minimum latency with an always-ready slave:
  - cmd accepted at cycle 0.
  - aw/w (or ar) handshake at cycle 1.
  - b/r handshake at cycle 2 at the earliest.
  - rsp_valid at cycle 3.
- Counters: wr_count or rd_count increments on the b or r handshake. err_count increments in the same cycle when the captured resp != 0. Counters wrap modulo 2^CNT_WIDTH.
- No timeout: a stalled slave holds the FSM indefinitely.
- Reset mid-transaction clears all valids immediately and drops any partial transaction; counters reset.

Decomposition:
- Shared package: state encoding enum, AXI response constants (OKAY=0, SLVERR=2), and a function for strobe width (DATA_WIDTH/8).
- Single module; no sub-module is warranted (the FSM and capture registers are tightly coupled).

Test Plan:
- Write, slave always ready: cmd addr=0, wdata=25, wstrb=15 -> awaddr=0/wdata=25 for one cycle, bready asserted, rsp_valid at cycle 3, rsp_resp=0, wr_count=1.
- Write, skewed handshakes: awready delayed 3 cycles, wready immediate, addr=4, data=34 -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one bready window, rsp_resp=0.
- Read: cmd read addr=8, slave returns rdata=0xDEADBEEF, rresp=0 after 5 cycles of rvalid low -> rready held throughout, rsp_rdata=0xDEADBEEF, rd_count=1.
- Error plus backpressure: read addr=12 with rresp=2, rsp_ready low for 4 cycles -> rsp_valid and rsp_resp=2 held stable, cmd_ready=0 throughout, err_count=1.
- Reset mid-write: assert aresetn=0 while awvalid=1 -> awvalid/wvalid are 0 in the same timestep, state IDLE, counters 0; a fresh write after release completes normally.
- Early bvalid: slave asserts bvalid before the w handshake -> bready stays 0 until both aw and w complete, then a single completion is counted.
